steer_input_sequencer: RTL and testbench
========================================

# steer_input_sequencer

Game-flow sequencer that owns the left/right steering commands feeding `steering_controller`. It synchronises and debounces the raw player buttons and runs an attract/countdown/play/crash state machine. Depending on state, the steering commands come from the player, from a built-in autopilot, or are forced idle. It sits between the board button inputs and the steering datapath, and uses the same `frame_pulse` tick.

## Interface
- `DEB_FRAMES`, 2: consecutive equal frame samples required to accept a button level (1..15).
- `COUNT_FRAMES`, 60: frames per countdown step (1..255).
- `CRASH_FRAMES`, 120: frames held in CRASH before returning to ATTRACT (1..255).
- `AUTO_BAND`, 40: autopilot weave amplitude, in offset units (1..79).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `frame_pulse`  in  1  one-clk-wide tick, once per video frame.
- `left_raw`, `right_raw`, `start_raw`  in  1 each  asynchronous board buttons, active-high.
- `crash`  in  1  one-clk pulse from collision logic.
- `lateral_offset`  in  11 signed  current offset fed back from the steering block.
- `left_cmd`, `right_cmd`  out  1 each  registered steering commands.
- `game_state`  out  2  00 ATTRACT, 01 COUNTDOWN, 10 PLAY, 11 CRASH.
- `countdown`  out  2  remaining countdown digit (3..1); 0 outside COUNTDOWN.

## Operation
- **Input path:** each raw button passes through a 2-FF synchroniser. Debounce runs only on `frame_pulse`:
  - Sample equals the accepted level → per-button counter clears.
  - Sample differs → counter increments.
  - When the counter reaches `DEB_FRAMES`, the accepted level takes the sample value and the counter clears.
- **Start edge:** a one-clk internal `start_evt` fires when the accepted start level goes 0→1.
- **ATTRACT (reset state):** the autopilot drives the commands.
  - The direction register `auto_dir` resets to 1 (right).
  - `auto_dir`=1 → `right_cmd`=1, `left_cmd`=0. When `lateral_offset >= AUTO_BAND` (signed compare), `auto_dir` becomes 0.
  - `auto_dir`=0 → `left_cmd`=1, `right_cmd`=0. When `lateral_offset <= -AUTO_BAND`, `auto_dir` becomes 1.
  - `start_evt` → COUNTDOWN, with `countdown`=3 and the frame counter cleared.
- **COUNTDOWN:** both commands are 0, so the steering block self-centres.
  - The frame counter increments on each `frame_pulse`.
  - When the counter reaches `COUNT_FRAMES`, it clears and `countdown` decrements.
  - A decrement from 1 goes to PLAY, with `countdown`=0.
- **PLAY:** `left_cmd`/`right_cmd` equal the accepted left/right levels.
  - Both pressed → both asserted; the steering block treats this as a no-op.
  - `crash` → CRASH, with the frame counter cleared.
- **CRASH:** both commands are 0. After `CRASH_FRAMES` frame pulses → ATTRACT, with `auto_dir`=1.
- **Ignored events:**
  - `start_evt` in COUNTDOWN, PLAY or CRASH.
  - `crash` outside PLAY.
- **Simultaneous events:**
  - In PLAY, `crash` wins over any button change.
  - `start_evt` and the ATTRACT band-flip in the same clock: the state change wins and `auto_dir` is don't-care.
- **Counter widths:** frame counter 8 bits unsigned, debounce counters 4 bits, no wrap within legal parameter ranges. `lateral_offset` is compared as 11-bit signed; `AUTO_BAND` is sign-extended to 11 bits.

## Timing
- **Reset values:** `left_cmd`=0, `right_cmd`=0, `game_state`=00, `countdown`=0.
  - Internal: `auto_dir`=1, accepted levels 0, all counters 0, synchronisers 0.
- **Button latency:** raw edge → synchroniser 2 clk → accepted after `DEB_FRAMES` frame pulses → command updated 1 clk later.
- **State transitions:**
  - Take effect the clock edge after the qualifying event, whether that is `frame_pulse`, `crash` or `start_evt`.
  - `game_state` and `countdown` change on the same edge.
  - Commands reflect the new state on that same edge; there is no cycle with the old state's commands.
- **Autopilot:** commands react to `lateral_offset` with 1-clk registered latency.
- **Mid-operation reset:** asserting `reset` in any state immediately forces all reset values, asynchronously. Release returns to ATTRACT.

## Test plan
- **Reset and autopilot:** reset, idle buttons, model `lateral_offset` +3 per frame while `right_cmd` is high → `right_cmd`=1 until offset ≥40. The next clk gives `left_cmd`=1, `right_cmd`=0; reversal again at offset ≤-40.
- **Debounce:** in PLAY, pulse `left_raw` high for 1 frame → `left_cmd` stays 0. Hold it for 2 frames → `left_cmd`=1 one clk after the 2nd frame pulse.
- **Countdown:** press start in ATTRACT → `game_state`=01, `countdown`=3 with both commands 0. The digit steps 3→2→1 every 60 frames; after 180 frames → `game_state`=10, `countdown`=0.
- **Crash hold and ignored start:** in PLAY with `right_raw` held, pulse `crash` → next clk `game_state`=11 and `right_cmd`=0. A start press during CRASH is ignored. After 120 frames → `game_state`=00 with the autopilot driving right.
- **Priority and filtering:** `crash` in the same clk as a debounced left acceptance → CRASH with `left_cmd`=0. `crash` pulsed in ATTRACT or COUNTDOWN → no state change.
- **Reset mid-countdown:** assert `reset` at `countdown`=2 → all outputs return to reset values asynchronously. After release the block is in ATTRACT.

Source files
------------

// File: rtl/steer_input_sequencer.sv
// Game-flow sequencer: synchronises/debounces the player buttons and chooses whether
// the steering commands come from the player, the attract-mode autopilot, or are idle.

module steer_btn_debounce #(
    parameter int DEB_FRAMES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_pulse,
    input  logic raw,
    output logic level
);
    logic [1:0] sync;
    logic [3:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (frame_pulse) begin
                if (sync[1] == level) begin
                    cnt <= '0;
                end else if (cnt == 4'(DEB_FRAMES - 1)) begin
                    level <= sync[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end
endmodule

module steer_input_sequencer #(
    parameter int DEB_FRAMES   = 2,
    parameter int COUNT_FRAMES = 60,
    parameter int CRASH_FRAMES = 120,
    parameter int AUTO_BAND    = 40
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_pulse,
    input  logic               left_raw,
    input  logic               right_raw,
    input  logic               start_raw,
    input  logic               crash,
    input  logic signed [10:0] lateral_offset,
    output logic               left_cmd,
    output logic               right_cmd,
    output logic [1:0]         game_state,
    output logic [1:0]         countdown
);
    localparam int NUM_BTN = 3;
    localparam logic signed [10:0] BAND     = 11'(AUTO_BAND);
    localparam logic signed [10:0] NEG_BAND = -BAND;

    typedef enum logic [1:0] {
        ST_ATTRACT   = 2'b00,
        ST_COUNTDOWN = 2'b01,
        ST_PLAY      = 2'b10,
        ST_CRASH     = 2'b11
    } state_t;

    // acc bit order: 0 = left, 1 = right, 2 = start
    logic [NUM_BTN-1:0] raw_bus;
    logic [NUM_BTN-1:0] acc;

    assign raw_bus = {start_raw, right_raw, left_raw};

    steer_btn_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_btn [NUM_BTN-1:0] (
        .clk        (clk),
        .reset      (reset),
        .frame_pulse(frame_pulse),
        .raw        (raw_bus),
        .level      (acc)
    );

    state_t     state;
    logic [7:0] frame_cnt;
    logic       auto_dir;
    logic       auto_nxt;
    logic       start_prev;
    logic       start_evt;

    assign start_evt  = acc[2] & ~start_prev;
    assign game_state = state;

    // Commands are registered from the next direction so the autopilot reacts in one clock.
    always_comb begin
        auto_nxt = auto_dir;
        if (auto_dir && (lateral_offset >= BAND))
            auto_nxt = 1'b0;
        else if (!auto_dir && (lateral_offset <= NEG_BAND))
            auto_nxt = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_ATTRACT;
            countdown  <= 2'd0;
            frame_cnt  <= 8'd0;
            auto_dir   <= 1'b1;
            start_prev <= 1'b0;
            left_cmd   <= 1'b0;
            right_cmd  <= 1'b0;
        end else begin
            start_prev <= acc[2];
            case (state)
                ST_ATTRACT: begin
                    if (start_evt) begin
                        state     <= ST_COUNTDOWN;
                        countdown <= 2'd3;
                        frame_cnt <= 8'd0;
                        left_cmd  <= 1'b0;
                        right_cmd <= 1'b0;
                    end else begin
                        auto_dir  <= auto_nxt;
                        left_cmd  <= ~auto_nxt;
                        right_cmd <= auto_nxt;
                    end
                end
                ST_COUNTDOWN: begin
                    left_cmd  <= 1'b0;
                    right_cmd <= 1'b0;
                    if (frame_pulse) begin
                        if (frame_cnt == 8'(COUNT_FRAMES - 1)) begin
                            frame_cnt <= 8'd0;
                            if (countdown == 2'd1) begin
                                state     <= ST_PLAY;
                                countdown <= 2'd0;
                                left_cmd  <= acc[0];
                                right_cmd <= acc[1];
                            end else begin
                                countdown <= countdown - 2'd1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (crash) begin
                        state     <= ST_CRASH;
                        frame_cnt <= 8'd0;
                        left_cmd  <= 1'b0;
                        right_cmd <= 1'b0;
                    end else begin
                        left_cmd  <= acc[0];
                        right_cmd <= acc[1];
                    end
                end
                ST_CRASH: begin
                    left_cmd  <= 1'b0;
                    right_cmd <= 1'b0;
                    if (frame_pulse) begin
                        if (frame_cnt == 8'(CRASH_FRAMES - 1)) begin
                            state     <= ST_ATTRACT;
                            frame_cnt <= 8'd0;
                            auto_dir  <= 1'b1;
                            right_cmd <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                default: state <= ST_ATTRACT;
            endcase
        end
    end
endmodule

// File: tb/tb_steer_input_sequencer.sv
// Scoreboard bench for steer_input_sequencer: expected {state,digit,left,right}
// tuples are queued as stimulus is applied and compared as the outputs settle.

module tb_steer_input_sequencer;
    localparam int DEB   = 2;
    localparam int COUNT = 60;
    localparam int CRASH = 120;
    localparam int BAND  = 40;

    logic clk = 1'b0;
    logic reset, frame_pulse, left_raw, right_raw, start_raw, crash;
    logic signed [10:0] lateral_offset;
    logic left_cmd, right_cmd;
    logic [1:0] game_state, countdown;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string      tag;
        logic [5:0] val;
    } exp_t;
    exp_t sb[$];

    steer_input_sequencer #(
        .DEB_FRAMES(DEB), .COUNT_FRAMES(COUNT), .CRASH_FRAMES(CRASH), .AUTO_BAND(BAND)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_pulse   (frame_pulse),
        .left_raw      (left_raw),
        .right_raw     (right_raw),
        .start_raw     (start_raw),
        .crash         (crash),
        .lateral_offset(lateral_offset),
        .left_cmd      (left_cmd),
        .right_cmd     (right_cmd),
        .game_state    (game_state),
        .countdown     (countdown)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got {st,cd,l,r}=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [1:0] gs, input logic [1:0] cd,
                        input logic l, input logic r);
        exp_t e;
        e.tag = tag;
        e.val = {gs, cd, l, r};
        sb.push_back(e);
    endtask

    task automatic pop();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_underflow", 6'd0, 6'h3f);
        end else begin
            e = sb.pop_front();
            chk(e.tag, {game_state, countdown, left_cmd, right_cmd}, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_pulse = 1'b1;
            tick();
            frame_pulse = 1'b0;
            tick();
            tick();
        end
    endtask

    // Drive new button levels, let them cross the synchroniser, then debounce them in.
    task automatic btn(input logic l, input logic r, input logic s);
        left_raw  = l;
        right_raw = r;
        start_raw = s;
        tick();
        tick();
        frames(DEB);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; frame_pulse = 1'b0; crash = 1'b0;
        left_raw = 1'b0; right_raw = 1'b0; start_raw = 1'b0;
        lateral_offset = '0;
        tick(); tick();
        push("reset", 2'b00, 2'd0, 1'b0, 1'b0); pop();
        reset = 1'b0;
        push("attract_first", 2'b00, 2'd0, 1'b0, 1'b1); tick(); pop();

        // Autopilot weave: right until offset >= BAND, then left until offset <= -BAND.
        for (int k = 0; k <= 14; k++) begin
            lateral_offset = 11'(3 * k);
            push($sformatf("auto_up_%0d", 3 * k), 2'b00, 2'd0,
                 (3 * k >= BAND), (3 * k < BAND));
            tick(); pop();
        end
        for (int k = 1; k <= 28; k++) begin
            int off;
            off = 42 - 3 * k;
            lateral_offset = 11'(off);
            push($sformatf("auto_down_%0d", off), 2'b00, 2'd0, (off > -BAND), (off <= -BAND));
            tick(); pop();
        end
        lateral_offset = '0;
        tick();

        push("crash_in_attract", 2'b00, 2'd0, 1'b0, 1'b1);
        crash = 1'b1; tick(); crash = 1'b0; pop();

        // First game: countdown digit steps then PLAY.
        push("cd_enter", 2'b01, 2'd3, 1'b0, 1'b0); btn(0, 0, 1); pop();
        btn(0, 0, 0);
        frames(COUNT - 3);
        push("cd3_hold", 2'b01, 2'd3, 1'b0, 1'b0); pop();
        frames(1);
        push("cd2", 2'b01, 2'd2, 1'b0, 1'b0); pop();
        push("crash_in_cd", 2'b01, 2'd2, 1'b0, 1'b0);
        crash = 1'b1; tick(); crash = 1'b0; pop();
        frames(COUNT - 1);
        push("cd2_hold", 2'b01, 2'd2, 1'b0, 1'b0); pop();
        frames(1);
        push("cd1", 2'b01, 2'd1, 1'b0, 1'b0); pop();
        frames(COUNT - 1);
        push("cd1_hold", 2'b01, 2'd1, 1'b0, 1'b0); pop();
        frames(1);
        push("play_enter", 2'b10, 2'd0, 1'b0, 1'b0); pop();

        // Debounce: a one-frame glitch is rejected, a two-frame hold is accepted.
        left_raw = 1'b1; tick(); tick(); frames(1);
        left_raw = 1'b0; tick(); tick(); frames(1);
        push("deb_glitch", 2'b10, 2'd0, 1'b0, 1'b0); pop();
        left_raw = 1'b1; tick(); tick(); frames(1);
        frame_pulse = 1'b1; tick(); frame_pulse = 1'b0;
        push("deb_accept_edge", 2'b10, 2'd0, 1'b0, 1'b0); pop();
        push("deb_cmd", 2'b10, 2'd0, 1'b1, 1'b0); tick(); pop();
        tick(); tick();
        push("deb_release", 2'b10, 2'd0, 1'b0, 1'b0); btn(0, 0, 0); pop();
        push("play_right", 2'b10, 2'd0, 1'b0, 1'b1); btn(0, 1, 0); pop();

        // Crash hold with an ignored start press.
        push("crash_enter", 2'b11, 2'd0, 1'b0, 1'b0);
        crash = 1'b1; tick(); crash = 1'b0; pop();
        push("crash_ign_start", 2'b11, 2'd0, 1'b0, 1'b0); btn(0, 1, 1); pop();
        btn(0, 0, 0);
        frames(CRASH - 5);
        push("crash_hold", 2'b11, 2'd0, 1'b0, 1'b0); pop();
        frames(1);
        push("crash_exit", 2'b00, 2'd0, 1'b0, 1'b1); pop();

        // Second game: crash coincident with a left acceptance.
        push("cd_enter2", 2'b01, 2'd3, 1'b0, 1'b0); btn(0, 0, 1); pop();
        btn(0, 0, 0);
        frames(3 * COUNT - 2);
        push("play_enter2", 2'b10, 2'd0, 1'b0, 1'b0); pop();
        left_raw = 1'b1; tick(); tick(); frames(1);
        frame_pulse = 1'b1; crash = 1'b1; tick(); frame_pulse = 1'b0; crash = 1'b0;
        push("prio_crash", 2'b11, 2'd0, 1'b0, 1'b0); pop();
        push("prio_left_idle", 2'b11, 2'd0, 1'b0, 1'b0); tick(); pop();
        btn(0, 0, 0);
        frames(CRASH - 3);
        push("crash_hold2", 2'b11, 2'd0, 1'b0, 1'b0); pop();
        frames(1);
        push("crash_exit2", 2'b00, 2'd0, 1'b0, 1'b1); pop();

        // Third game: asynchronous reset while the digit shows 2.
        push("cd_enter3", 2'b01, 2'd3, 1'b0, 1'b0); btn(0, 0, 1); pop();
        btn(0, 0, 0);
        frames(COUNT - 2);
        push("cd2_pre_reset", 2'b01, 2'd2, 1'b0, 1'b0); pop();
        #3;
        reset = 1'b1;
        #1;
        push("reset_async", 2'b00, 2'd0, 1'b0, 1'b0); pop();
        tick(); tick();
        reset = 1'b0;
        push("reset_release", 2'b00, 2'd0, 1'b0, 1'b1); tick(); pop();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
